pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. Combines load-use detection, EX-stage branch redirect and the data-memory wait handshake into one prioritised set of pipeline-register enables and flushes. Adds a memory-wait timeout watchdog and stall/flush performance counters. Sits beside the pipeline registers: it drives their write enables and flush inputs and the PC write enable.

## Interface
- `MEM_TIMEOUT`, default 255: maximum consecutive MEM_WAIT cycles before the error is raised (1..65535).
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  single clock; all state on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_id_rs1`, `if_id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_ex_rd`  in  5  destination register of the instruction in EX.
- `id_ex_mem_read`  in  1  instruction in EX is a load.
- `ex_branch_taken`  in  1  EX resolved a taken branch or jump; PC mux selects the target.
- `mem_req`  in  1  MEM stage issues a data-memory access this cycle.
- `dmem_ready`  in  1  data memory completes the access this cycle.
- `pc_write`  out  1  PC register enable.
- `if_id_write`  out  1  IF/ID register enable.
- `id_ex_write`, `ex_mem_write`, `mem_wb_write`  out  1 each  remaining pipeline-register enables.
- `if_id_flush`, `id_ex_flush`  out  1 each  load a NOP/bubble into the register.
- `mem_timeout_err`  out  1  sticky error flag.
- `stall_cycles`  out  CNT_W  count of cycles with `pc_write` = 0.
- `flush_events`  out  CNT_W  count of branch-flush cycles.

## Operation
- FSM states: RUN, MEM_WAIT, ERROR. Reset state: RUN.
- Memory freeze is the highest priority, taken in RUN when `mem_req`=1 and `dmem_ready`=0, and in every MEM_WAIT cycle with `dmem_ready`=0.
  - All five enables are 0 and both flushes are 0.
  - RUN moves to MEM_WAIT; MEM_WAIT holds.
  - While frozen, `ex_branch_taken` and the load-use condition are ignored. They stay valid because EX and ID are held, and they act on the release cycle.
- Release: in MEM_WAIT with `dmem_ready`=1, the cycle is treated as a normal RUN cycle and the FSM returns to RUN. Any branch or load-use rule applies in this same cycle.
- Branch, second priority, when not frozen and `ex_branch_taken`=1:
  - `if_id_flush`=1 and `id_ex_flush`=1.
  - `pc_write`=1 and all enables 1.
  - Load-use is suppressed, because the ID instruction is squashed.
- Load-use, third priority: `id_ex_mem_read`=1, `id_ex_rd`≠0, and `id_ex_rd` equals `if_id_rs1` or `if_id_rs2`.
  - `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1 (bubble).
  - `id_ex_write`, `ex_mem_write` and `mem_wb_write` are 1.
- RUN with no event: all enables 1, flushes 0.
- Timeout:
  - A wait counter clears on MEM_WAIT entry and increments on each MEM_WAIT cycle.
  - If it reaches `MEM_TIMEOUT` with `dmem_ready` still 0, go to ERROR and set `mem_timeout_err`.
  - ERROR is terminal until `rst`: all enables 0, flushes 0.
- Counters:
  - `stall_cycles` increments on every cycle with `pc_write`=0, including freeze and ERROR cycles.
  - `flush_events` increments on every branch-flush cycle.
  - Both wrap modulo 2^CNT_W.

## Timing
- All enable and flush outputs are combinational from state and inputs (0-cycle latency), so they gate the same edge's register writes.
- FSM, wait counter, error flag and perf counters are registered and update on the rising edge.
- Reset values:
  - State RUN; wait counter 0; `mem_timeout_err`=0; `stall_cycles`=0; `flush_events`=0.
  - Combinational outputs at reset equal the RUN/no-event values for the current inputs.
- Load-use costs exactly one stall cycle. The next cycle sees a bubble in EX, so the condition clears.
- A memory access with `dmem_ready`=1 in its first cycle costs 0 cycles and never enters MEM_WAIT.
- N not-ready cycles cost N stall cycles, plus 0 extra on release.
- Reset asserted mid-MEM_WAIT or in ERROR returns the block to RUN immediately (asynchronous) and clears the counters.

## Structure
- Shared package `pipeline_ctrl_pkg`: state enum `hz_state_t` (RUN, MEM_WAIT, ERROR), the `REG_ZERO` constant, and a packed struct `pipe_ctrl_t` bundling the five enables and two flushes.
- One natural sub-module, `load_use_detect`: purely combinational comparison of rs1/rs2 against rd, with the rd≠0 qualifier.

## Test plan
- **Load-use:** `id_ex_mem_read`=1, `id_ex_rd`=5, `if_id_rs2`=5 → one cycle of `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1, then `stall_cycles`=1. The same stimulus with `id_ex_rd`=0 → no stall.
- **Branch over hazard:** `ex_branch_taken`=1 together with a load-use match → both flushes 1, `pc_write`=1, no stall, `flush_events`=1.
- **Memory wait:** `mem_req`=1 with `dmem_ready` low for 3 cycles, then high → 3 cycles with all enables 0, release on the 4th cycle, `stall_cycles`=3, state back to RUN.
- **Branch held during wait:** `ex_branch_taken`=1 during a 2-cycle memory wait → no flush while frozen, flush exactly on the release cycle, `flush_events`=1.
- **Timeout:** `MEM_TIMEOUT`=4 with `dmem_ready` held 0 → `mem_timeout_err`=1 after 4 MEM_WAIT cycles and stays 1. Then `dmem_ready`=1 → still frozen. Asserting `rst` → RUN, error and counters cleared.
- **Reset mid-wait:** `rst` asserted in MEM_WAIT between clock edges → outputs return to RUN values and all counters read 0 without waiting for a clock edge.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Enables and flushes for one cycle, MSB first: PC, IF/ID, ID/EX, EX/MEM, MEM/WB, flushes.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic mem_wb_write;
    logic if_id_flush;
    logic id_ex_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN    = 7'b11111_00;
  localparam pipe_ctrl_t CTRL_FREEZE = 7'b00000_00;
  localparam pipe_ctrl_t CTRL_FLUSH  = 7'b11111_11;
  localparam pipe_ctrl_t CTRL_BUBBLE = 7'b00111_01;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard: the EX load writes a register that the ID instruction reads.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic [4:0] rd_i,
  input  logic       mem_read_i,
  output logic       hazard_o
);

  // x0 is hard-wired to zero, so a load into it never creates a dependency.
  assign hazard_o = mem_read_i && (rd_i != REG_ZERO) &&
                    ((rd_i == rs1_i) || (rd_i == rs2_i));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Prioritised stall/flush sequencer: memory freeze > branch flush > load-use bubble.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  hz_state_t        state_q, state_d;
  logic [15:0]      wait_q, wait_d;
  logic [16:0]      wait_inc;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             load_use;
  pipe_ctrl_t       run_ctrl, ctrl;

  load_use_detect u_load_use (
    .rs1_i      (if_id_rs1),
    .rs2_i      (if_id_rs2),
    .rd_i       (id_ex_rd),
    .mem_read_i (id_ex_mem_read),
    .hazard_o   (load_use)
  );

  assign wait_inc = {1'b0, wait_q} + 17'd1;

  // Controls for an unfrozen cycle; a taken branch squashes ID so load-use is moot.
  always_comb begin
    run_ctrl = CTRL_RUN;
    if (ex_branch_taken) begin
      run_ctrl = CTRL_FLUSH;
    end else if (load_use) begin
      run_ctrl = CTRL_BUBBLE;
    end
  end

  // Next-state and output decode; frozen cycles ignore branch/load-use, which stay valid for release.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    ctrl    = run_ctrl;
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      RUN: begin
        if (mem_req && !dmem_ready) begin
          ctrl    = CTRL_FREEZE;
          state_d = MEM_WAIT;
          wait_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          ctrl   = CTRL_FREEZE;
          wait_d = wait_inc[15:0];
          if (wait_inc >= 17'(MEM_TIMEOUT)) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end else begin
          state_d = RUN;
        end
      end
      ERROR: begin
        ctrl = CTRL_FREEZE;
      end
      default: begin
        ctrl    = CTRL_FREEZE;
        state_d = ERROR;
      end
    endcase
  end

  // State, wait counter, sticky error and performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      stall_q <= stall_q + {{(CNT_W-1){1'b0}}, ~ctrl.pc_write};
      flush_q <= flush_q + {{(CNT_W-1){1'b0}}, ctrl.if_id_flush};
    end
  end

  assign pc_write        = ctrl.pc_write;
  assign if_id_write     = ctrl.if_id_write;
  assign id_ex_write     = ctrl.id_ex_write;
  assign ex_mem_write    = ctrl.ex_mem_write;
  assign mem_wb_write    = ctrl.mem_wb_write;
  assign if_id_flush     = ctrl.if_id_flush;
  assign id_ex_flush     = ctrl.id_ex_flush;
  assign mem_timeout_err = err_q;
  assign stall_cycles    = stall_q;
  assign flush_events    = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table plus multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       if_id_rs1, if_id_rs2, id_ex_rd;
  logic             id_ex_mem_read, ex_branch_taken, mem_req, dmem_ready;
  logic             pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic             if_id_flush, id_ex_flush, mem_timeout_err;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic [6:0]       ctrl_o;

  // Expected encodings: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
  localparam logic [6:0] E_RUN    = 7'b1111100;
  localparam logic [6:0] E_FREEZE = 7'b0000000;
  localparam logic [6:0] E_FLUSH  = 7'b1111111;
  localparam logic [6:0] E_BUBBLE = 7'b0011101;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] stall_exp = '0;
  logic [CNT_W-1:0] flush_exp = '0;
  logic             err_exp   = 1'b0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .if_id_rs1       (if_id_rs1),
    .if_id_rs2       (if_id_rs2),
    .id_ex_rd        (id_ex_rd),
    .id_ex_mem_read  (id_ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .dmem_ready      (dmem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_write     (id_ex_write),
    .ex_mem_write    (ex_mem_write),
    .mem_wb_write    (mem_wb_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .mem_timeout_err (mem_timeout_err),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
  );

  assign ctrl_o = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                   mem_wb_write, if_id_flush, id_ex_flush};

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       mr, br, mq, rdy;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(string n, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic mr, logic br, logic mq, logic rdy, logic [6:0] exp);
    vec_t v;
    v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.mr = mr; v.br = br; v.mq = mq; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic mr, input logic br, input logic mq, input logic rdy);
    @(negedge clk);
    if_id_rs1 = rs1; if_id_rs2 = rs2; id_ex_rd = rd;
    id_ex_mem_read = mr; ex_branch_taken = br; mem_req = mq; dmem_ready = rdy;
  endtask

  // Check combinational controls, clock once, then check the registered side.
  task automatic step(input string name, input logic [6:0] exp);
    #1;
    check({name, " ctrl"}, 32'(ctrl_o), 32'(exp));
    @(posedge clk);
    if (!exp[6]) stall_exp = stall_exp + 1;
    if (exp[1])  flush_exp = flush_exp + 1;
    #1;
    check({name, " stall_cycles"}, stall_cycles, stall_exp);
    check({name, " flush_events"}, flush_events, flush_exp);
    check({name, " mem_timeout_err"}, 32'(mem_timeout_err), 32'(err_exp));
  endtask

  // Asynchronous reset between edges: outputs and counters must clear with no clock.
  task automatic async_reset(input string name);
    #2;
    rst = 1'b1;
    if_id_rs1 = 5'd0; if_id_rs2 = 5'd0; id_ex_rd = 5'd0;
    id_ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; dmem_ready = 1'b0;
    #1;
    check({name, " ctrl"}, 32'(ctrl_o), 32'(E_RUN));
    check({name, " err"}, 32'(mem_timeout_err), 32'd0);
    check({name, " stall_cycles"}, stall_cycles, 32'd0);
    check({name, " flush_events"}, flush_events, 32'd0);
    stall_exp = '0; flush_exp = '0; err_exp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk("idle",              5'd0,  5'd0,  5'd0,  0, 0, 0, 0, E_RUN);
    vecs[1]  = mk("load_use_rs2",      5'd1,  5'd5,  5'd5,  1, 0, 0, 0, E_BUBBLE);
    vecs[2]  = mk("load_use_rd_zero",  5'd0,  5'd0,  5'd0,  1, 0, 0, 0, E_RUN);
    vecs[3]  = mk("load_use_rs1",      5'd7,  5'd2,  5'd7,  1, 0, 0, 0, E_BUBBLE);
    vecs[4]  = mk("no_load_match",     5'd7,  5'd2,  5'd7,  0, 0, 0, 0, E_RUN);
    vecs[5]  = mk("load_no_match",     5'd3,  5'd4,  5'd5,  1, 0, 0, 0, E_RUN);
    vecs[6]  = mk("branch_over_haz",   5'd1,  5'd5,  5'd5,  1, 1, 0, 0, E_FLUSH);
    vecs[7]  = mk("branch_alone",      5'd0,  5'd0,  5'd0,  0, 1, 0, 0, E_FLUSH);
    vecs[8]  = mk("mem_ready_haz",     5'd5,  5'd9,  5'd5,  1, 0, 1, 1, E_BUBBLE);
    vecs[9]  = mk("mem_ready_1st",     5'd0,  5'd0,  5'd0,  0, 0, 1, 1, E_RUN);
    vecs[10] = mk("load_use_x31",      5'd31, 5'd31, 5'd31, 1, 0, 0, 0, E_BUBBLE);

    rst = 1'b1;
    if_id_rs1 = 5'd0; if_id_rs2 = 5'd0; id_ex_rd = 5'd0;
    id_ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; dmem_ready = 1'b0;
    #2;
    check("reset ctrl", 32'(ctrl_o), 32'(E_RUN));
    check("reset err", 32'(mem_timeout_err), 32'd0);
    check("reset stall_cycles", stall_cycles, 32'd0);
    check("reset flush_events", flush_events, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].mr, vecs[i].br, vecs[i].mq, vecs[i].rdy);
      step(vecs[i].name, vecs[i].exp);
    end

    // Memory wait: three not-ready cycles then release, back in RUN afterwards.
    drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 0); step("memwait c1", E_FREEZE);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 0); step("memwait c2", E_FREEZE);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 0); step("memwait c3", E_FREEZE);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 1); step("memwait release", E_RUN);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0); step("memwait back_in_run", E_RUN);

    // Branch held across a two-cycle wait flushes only on release.
    drive(5'd0, 5'd0, 5'd0, 0, 1, 1, 0); step("brwait c1", E_FREEZE);
    drive(5'd0, 5'd0, 5'd0, 0, 1, 1, 0); step("brwait c2", E_FREEZE);
    drive(5'd0, 5'd0, 5'd0, 0, 1, 1, 1); step("brwait release", E_FLUSH);

    // Load-use held across a one-cycle wait bubbles on release.
    drive(5'd4, 5'd0, 5'd4, 1, 0, 1, 0); step("luwait c1", E_FREEZE);
    drive(5'd4, 5'd0, 5'd4, 1, 0, 1, 1); step("luwait release", E_BUBBLE);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0); step("luwait after", E_RUN);

    // Timeout: entry cycle, then the fourth MEM_WAIT cycle raises the error.
    drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 0); step("timeout entry", E_FREEZE);
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) err_exp = 1'b1;
      drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 0); step($sformatf("timeout wait%0d", k), E_FREEZE);
    end
    drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 1); step("error ready1", E_FREEZE);
    drive(5'd0, 5'd0, 5'd0, 0, 1, 1, 1); step("error branch", E_FREEZE);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    #1;
    check("error idle ctrl", 32'(ctrl_o), 32'(E_FREEZE));
    async_reset("reset from error");
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0); step("after error reset", E_RUN);

    // Reset asserted while in MEM_WAIT.
    drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 0); step("rstwait entry", E_FREEZE);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0); step("rstwait hold", E_FREEZE);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    #1;
    check("rstwait frozen ctrl", 32'(ctrl_o), 32'(E_FREEZE));
    async_reset("reset mid wait");
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0); step("after wait reset", E_RUN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
